// File: rtl/wb_button_poll_master.sv
// -----------------------------------------------------------------------------
// wb_button_poll_master
//
// Stand-alone Wishbone classic initiator for the button/LED responder. A poll
// timer periodically triggers a read of the button register. Rising button
// edges bump press_count, and each change of press_count is written to the
// LED register. Transactions that see no ack within TIMEOUT cycles are
// abandoned and counted.
//
// Ports:
//   clk            clock, rising edge
//   reset          asynchronous active-high reset
//   enable         runs the poll timer
//   o_wb_cyc/stb   bus cycle / strobe (identical)
//   o_wb_we        1 = write
//   o_wb_sel       byte select, 4'hF while a transaction is active
//   o_wb_addr      transaction address
//   o_wb_data      write data
//   i_wb_ack       responder acknowledge
//   i_wb_data      read data (bits [2:0] are the buttons)
//   buttons        last successfully read button value
//   press_count    number of polls that saw a rising button edge (wraps)
//   busy           high while a transaction is active
//   timeout_err    one-cycle pulse when a transaction is abandoned
//   timeout_count  number of abandoned transactions (saturating)
// -----------------------------------------------------------------------------
module wb_button_poll_master #(
    parameter logic [31:0] BTN_ADDR    = 32'h3000_0000,
    parameter logic [31:0] LED_ADDR    = 32'h3000_0004,
    parameter int unsigned POLL_CYCLES = 1000,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [3:0]  o_wb_sel,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    input  logic        i_wb_ack,
    input  logic [31:0] i_wb_data,
    output logic [2:0]  buttons,
    output logic [7:0]  press_count,
    output logic        busy,
    output logic        timeout_err,
    output logic [7:0]  timeout_count
);

    localparam int unsigned TW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [TW-1:0] RELOAD   = TW'(POLL_CYCLES - 1);
    localparam logic [7:0]    WAIT_MAX = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [TW-1:0] r_timer;
    logic [7:0]    r_wait;
    logic          r_wr_pend;
    logic [2:0]    r_buttons;
    logic [7:0]    r_press_count;
    logic          r_timeout_err;
    logic [7:0]    r_timeout_count;

    logic          w_tick;
    logic          w_active;
    logic          w_timeout;
    logic [2:0]    w_rise;
    logic          w_unused_data;

    assign w_tick        = enable && (r_timer == '0);
    assign w_active      = (r_state == ST_RD) || (r_state == ST_WR);
    // The wait counter holds the number of ack-less cycles already spent; the
    // TIMEOUT-th ack-less cycle abandons the transaction unless it carries ack.
    assign w_timeout     = w_active && !i_wb_ack && (r_wait == WAIT_MAX);
    assign w_rise        = i_wb_data[2:0] & ~r_buttons;
    assign w_unused_data = ^i_wb_data[31:3];

    // Next-state logic. The write is deferred through r_wr_pend so that one
    // idle bus cycle always separates the read from the write.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (r_wr_pend) begin
                    w_next_state = ST_WR;
                end else if (w_tick) begin
                    w_next_state = ST_RD;
                end
            end
            ST_RD, ST_WR: begin
                if (i_wb_ack || w_timeout) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_timer         <= RELOAD;
            r_wait          <= '0;
            r_wr_pend       <= 1'b0;
            r_buttons       <= '0;
            r_press_count   <= '0;
            r_timeout_err   <= 1'b0;
            r_timeout_count <= '0;
        end else begin
            r_state <= w_next_state;

            if (!enable || r_timer == '0) begin
                r_timer <= RELOAD;
            end else begin
                r_timer <= r_timer - 1'b1;
            end

            if (r_state == ST_IDLE || w_next_state == ST_IDLE) begin
                r_wait <= '0;
            end else begin
                r_wait <= r_wait + 1'b1;
            end

            r_wr_pend <= (r_state == ST_RD) && i_wb_ack && (w_rise != '0);

            if (r_state == ST_RD && i_wb_ack) begin
                r_buttons <= i_wb_data[2:0];
                if (w_rise != '0) begin
                    r_press_count <= r_press_count + 1'b1;
                end
            end

            r_timeout_err <= w_timeout;
            if (w_timeout && r_timeout_count != 8'hFF) begin
                r_timeout_count <= r_timeout_count + 1'b1;
            end
        end
    end

    // Bus outputs decode straight from the state flop so that an asynchronous
    // reset releases the bus without waiting for a clock edge.
    always_comb begin
        o_wb_cyc  = 1'b0;
        o_wb_we   = 1'b0;
        o_wb_sel  = '0;
        o_wb_addr = '0;
        o_wb_data = '0;
        unique case (r_state)
            ST_RD: begin
                o_wb_cyc  = 1'b1;
                o_wb_sel  = '1;
                o_wb_addr = BTN_ADDR;
            end
            ST_WR: begin
                o_wb_cyc  = 1'b1;
                o_wb_we   = 1'b1;
                o_wb_sel  = '1;
                o_wb_addr = LED_ADDR;
                o_wb_data = {24'h0, r_press_count};
            end
            default: ;
        endcase
    end

    assign o_wb_stb      = o_wb_cyc;
    assign busy          = o_wb_cyc;
    assign buttons       = r_buttons;
    assign press_count   = r_press_count;
    assign timeout_err   = r_timeout_err;
    assign timeout_count = r_timeout_count;

endmodule
